mem_load_arbiter: RTL and testbench
===================================

MEM_LOAD_ARBITER -- requirements
Module: mem_load_arbiter

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, number of program words; AW, 4, address width; DW, 8, data width.
REQ-002 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port load_start  input  1  one-cycle request to begin a program download.
REQ-005 Port ld_valid  input  1  loader byte valid.
REQ-006 Port ld_data  input  DW  loader byte.
REQ-007 Port ld_ready  output  1  arbiter accepts a byte this cycle; a byte is taken when ld_valid and ld_ready are both high.
REQ-008 Port cpu_re  input  1  CPU read enable from the control unit.
REQ-009 Port cpu_raddr  input  AW  CPU read address from the MAR.
REQ-010 Port mem_re  output  1  read enable to the 16x8 memory.
REQ-011 Port mem_raddr  output  AW  read address to memory.
REQ-012 Port mem_we  output  1  write strobe to memory.
REQ-013 Port mem_waddr  output  AW  write address to memory.
REQ-014 Port mem_wdata  output  DW  write data to memory.
REQ-015 Port cpu_hold  output  1  holds the CPU (PC reset and control unit reset) while high.
REQ-016 Port done  output  1  a verified program is loaded and the CPU is running.
REQ-017 Port error  output  1  last download failed checksum.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, CHECK, RUN and ERR, held in a registered state variable.
REQ-019 In IDLE, RUN or ERR, load_start high SHALL move to LOAD next cycle, clearing the write address counter and the 8-bit checksum accumulator to 0.
REQ-020 ld_ready SHALL be combinational: high only in LOAD or CHECK, and only while load_start is low.
REQ-021 In LOAD, each accepted byte SHALL add ld_data to the checksum modulo 256 and produce, on the next cycle, a one-cycle mem_we with mem_waddr equal to the counter value at acceptance and mem_wdata equal to the byte.
REQ-022 The write address counter SHALL increment per accepted byte; after DEPTH bytes (address 15 accepted) the FSM SHALL go to CHECK; the counter SHALL never wrap to 0 within a download.
REQ-023 In CHECK, the next accepted byte SHALL be the checksum byte and SHALL NOT be written to memory; if (accumulator + byte) mod 256 = 0 the FSM SHALL go to RUN, otherwise to ERR.
REQ-024 load_start high in LOAD or CHECK SHALL restart the download (counter and accumulator cleared, state LOAD); a byte presented in that cycle SHALL NOT be accepted.
REQ-025 cpu_hold SHALL be 1 in every state except RUN, and SHALL go low on the first cycle in RUN.
REQ-026 done SHALL be 1 only in RUN; error SHALL be 1 only in ERR; both registered.
REQ-027 The read port SHALL be granted to the CPU only in RUN: mem_re = cpu_re and mem_raddr = cpu_raddr, combinational; in all other states mem_re SHALL be 0 and mem_raddr 0.
REQ-028 mem_we SHALL never be high in RUN, IDLE or ERR except for the pending write of a byte accepted in the preceding LOAD cycle.
REQ-029 ld_valid without ld_ready SHALL have no effect; ld_valid may stay high across several bytes (one byte per cycle throughput).

Reset
REQ-030 While rst is high, the FSM SHALL be IDLE, counter and accumulator 0, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_hold 1, done 0, error 0, independent of clk.
REQ-031 Reset asserted mid-download SHALL abandon the download immediately with no further mem_we; the next download SHALL require a new load_start.

Verification
REQ-032 Good load: load_start, then bytes 0x00..0x0F back-to-back, then checksum 0x88 -> 16 mem_we pulses with waddr=data, done=1, error=0, cpu_hold=0, cpu_re/cpu_raddr=5 visible on mem_re/mem_raddr.
REQ-033 Bad checksum: same 16 bytes, checksum 0x00 -> ERR, error=1, done=0, cpu_hold=1, mem_re stays 0 with cpu_re=1.
REQ-034 Gapped valid: ld_valid toggled every other cycle for 16 bytes of 0xFF plus checksum 0x10 -> exactly 16 writes, RUN reached.
REQ-035 Restart: load_start after 7 bytes, concurrent ld_valid byte 0xAA not accepted -> counter restarts at 0, next write at address 0.
REQ-036 Async reset after 10 bytes, asserted between clock edges -> outputs at reset values before the next edge, no further mem_we.
REQ-037 Reload from RUN: load_start in RUN -> cpu_hold=1 and done=0 next cycle, mem_re forced 0 until RUN re-entered.

Source files
------------

// File: rtl/mem_load_arbiter.sv
// Program-memory arbiter: downloads DEPTH bytes plus a checksum byte from a loader,
// then hands the memory read port to the CPU once the image has verified.
module mem_load_arbiter #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_raddr,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [2:0]    stateDbg
);

    // Loader handshake: a byte transfers on a rising edge where ld_valid and
    // ld_ready are both high; ld_ready never depends on ld_valid.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } stateT;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    stateT         state, stateNext;
    logic [AW-1:0] addrCnt, addrCntNext;
    logic [DW-1:0] checksum, checksumNext;
    logic [DW-1:0] sumNow;
    logic          accept;
    logic          weNext;

    logic          weReg;
    logic [AW-1:0] waddrReg;
    logic [DW-1:0] wdataReg;
    logic          holdReg;
    logic          doneReg;
    logic          errorReg;

    assign ld_ready = ((state == LOAD) || (state == CHECK)) && !load_start;
    assign accept   = ld_valid && ld_ready;
    assign sumNow   = checksum + ld_data;

    always_comb begin
        stateNext    = state;
        addrCntNext  = addrCnt;
        checksumNext = checksum;
        weNext       = 1'b0;
        if (load_start) begin
            stateNext    = LOAD;
            addrCntNext  = '0;
            checksumNext = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        checksumNext = sumNow;
                        weNext       = 1'b1;
                        // Counter parks on the last address instead of wrapping.
                        if (addrCnt == LAST_ADDR) begin
                            stateNext = CHECK;
                        end else begin
                            addrCntNext = addrCnt + AW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        stateNext = (sumNow == '0) ? RUN : ERR;
                    end
                end
                default: begin
                    stateNext = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addrCnt  <= '0;
            checksum <= '0;
        end else begin
            state    <= stateNext;
            addrCnt  <= addrCntNext;
            checksum <= checksumNext;
        end
    end

    // Write port lags acceptance by one cycle; reset kills any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weReg    <= 1'b0;
            waddrReg <= '0;
            wdataReg <= '0;
        end else begin
            weReg <= weNext;
            if (weNext) begin
                waddrReg <= addrCnt;
                wdataReg <= ld_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdReg  <= 1'b1;
            doneReg  <= 1'b0;
            errorReg <= 1'b0;
        end else begin
            holdReg  <= (stateNext != RUN);
            doneReg  <= (stateNext == RUN);
            errorReg <= (stateNext == ERR);
        end
    end

    assign mem_we    = weReg;
    assign mem_waddr = waddrReg;
    assign mem_wdata = wdataReg;
    assign cpu_hold  = holdReg;
    assign done      = doneReg;
    assign error     = errorReg;
    assign stateDbg  = state;

    // Read port belongs to the CPU only while a verified image is running.
    assign mem_re    = (state == RUN) ? cpu_re : 1'b0;
    assign mem_raddr = (state == RUN) ? cpu_raddr : '0;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Testbench for mem_load_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic checked against a download-level model.
module tb_mem_load_arbiter;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       cpu_re;
    logic [3:0] cpu_raddr;
    logic       mem_re;
    logic [3:0] mem_raddr;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [2:0] stateDbg;

    mem_load_arbiter #(.DEPTH(16), .AW(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_re(cpu_re), .cpu_raddr(cpu_raddr),
        .mem_re(mem_re), .mem_raddr(mem_raddr),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .stateDbg(stateDbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nChecks = 0;
    int nErrors = 0;
    int weSeen  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a download is a list of received bytes; outcome 0 none, 1 verified, 2 bad.
    logic        active;
    logic [7:0]  got[$];
    int          outcome;
    logic        expWe;
    logic [3:0]  expWaddr;
    logic [7:0]  expWdata;
    logic [11:0] exp_q[$];

    function automatic int gotSum();
        int s = 0;
        foreach (got[i]) s += got[i];
        return s;
    endfunction

    task automatic modelReset();
        active  = 1'b0;
        got.delete();
        outcome = 0;
        expWe   = 1'b0;
        exp_q.delete();
    endtask

    task automatic modelUpdate();
        expWe = 1'b0;
        if (rst) begin
            modelReset();
        end else if (load_start) begin
            active  = 1'b1;
            got.delete();
            outcome = 0;
        end else if (active && ld_valid) begin
            if (got.size() < 16) begin
                expWe    = 1'b1;
                expWaddr = 4'(got.size());
                expWdata = ld_data;
                exp_q.push_back({expWaddr, expWdata});
                got.push_back(ld_data);
            end else begin
                outcome = (((gotSum() + int'(ld_data)) % 256) == 0) ? 1 : 2;
                active  = 1'b0;
            end
        end
    endtask

    task automatic preEdge();
        logic running;
        #1;
        running = (outcome == 1) && !active;
        chk("ld_ready", ld_ready, active && !load_start);
        chk("mem_re", mem_re, running ? cpu_re : 1'b0);
        chk("mem_raddr", mem_raddr, running ? cpu_raddr : 4'd0);
    endtask

    task automatic postEdge();
        logic [11:0] w;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        if (mem_we) weSeen++;
        chk("mem_we", mem_we, expWe);
        if (expWe) begin
            chk("mem_waddr", mem_waddr, expWaddr);
            chk("mem_wdata", mem_wdata, expWdata);
        end
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                chk("write_unexpected", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("write_scoreboard", {mem_waddr, mem_wdata}, w);
            end
        end
        chk("done", done, (outcome == 1) && !active);
        chk("error", error, (outcome == 2) && !active);
        chk("cpu_hold", cpu_hold, !((outcome == 1) && !active));
    endtask

    task automatic drive(input logic ls, input logic vld, input logic [7:0] data,
                         input logic cre, input logic [3:0] craddr);
        load_start = ls;
        ld_valid   = vld;
        ld_data    = data;
        cpu_re     = cre;
        cpu_raddr  = craddr;
    endtask

    task automatic tick();
        preEdge();
        postEdge();
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_waddr"}, mem_waddr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_mem_re"}, mem_re, 0);
    endtask

    typedef struct {
        logic       ls;
        logic       vld;
        logic [7:0] data;
        logic       cre;
        logic [3:0] craddr;
        logic       eReady;
        logic       eMemRe;
        logic [3:0] eRaddr;
        logic       eWe;
        logic [3:0] eWaddr;
        logic [7:0] eWdata;
        logic       eDone;
        logic       eErr;
        logic       eHold;
    } vecT;

    vecT tbl[38];

    task automatic fillLoad(input int base, input logic [7:0] csum, input logic good);
        tbl[base] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,
                      1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            tbl[base + 1 + i] = '{1'b0, 1'b1, 8'(i), 1'b0, 4'd0, 1'b1, 1'b0, 4'd0,
                                  1'b1, 4'(i), 8'(i), 1'b0, 1'b0, 1'b1};
        end
        tbl[base + 17] = '{1'b0, 1'b1, csum, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0,
                           1'b0, 4'd0, 8'h00, good, !good, !good};
        tbl[base + 18] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 1'b0, good, good ? 4'd5 : 4'd0,
                           1'b0, 4'd0, 8'h00, good, !good, !good};
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        drive(0, 0, 8'h00, 1'b1, 4'd7);
        modelReset();
        #1;
        checkResetOutputs("reset_pre_clock");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 8'h00, 0, 4'd0);

        // Good image (checksum 0x88) then bad image (checksum 0x00), table driven.
        fillLoad(0, 8'h88, 1'b1);
        fillLoad(19, 8'h00, 1'b0);
        for (int r = 0; r < 38; r++) begin
            drive(tbl[r].ls, tbl[r].vld, tbl[r].data, tbl[r].cre, tbl[r].craddr);
            preEdge();
            chk($sformatf("tbl%0d_ld_ready", r), ld_ready, tbl[r].eReady);
            chk($sformatf("tbl%0d_mem_re", r), mem_re, tbl[r].eMemRe);
            chk($sformatf("tbl%0d_mem_raddr", r), mem_raddr, tbl[r].eRaddr);
            postEdge();
            chk($sformatf("tbl%0d_mem_we", r), mem_we, tbl[r].eWe);
            if (tbl[r].eWe) begin
                chk($sformatf("tbl%0d_waddr", r), mem_waddr, tbl[r].eWaddr);
                chk($sformatf("tbl%0d_wdata", r), mem_wdata, tbl[r].eWdata);
            end
            chk($sformatf("tbl%0d_done", r), done, tbl[r].eDone);
            chk($sformatf("tbl%0d_error", r), error, tbl[r].eErr);
            chk($sformatf("tbl%0d_cpu_hold", r), cpu_hold, tbl[r].eHold);
        end

        // Gapped valid: 16 x 0xFF plus checksum 0x10, valid every other cycle.
        drive(1, 0, 8'h00, 0, 4'd0);
        tick();
        weSeen = 0;
        for (int i = 0; i < 33; i++) begin
            d = (i < 32) ? 8'hFF : 8'h10;
            drive(0, (i % 2) == 0, d, 0, 4'd0);
            tick();
        end
        chk("gapped_write_count", weSeen, 16);
        chk("gapped_done", done, 1);

        // Reload from RUN: hold reasserts and read port is withdrawn.
        drive(1, 0, 8'h00, 1, 4'd3);
        preEdge();
        chk("reload_mem_re_before", mem_re, 1);
        chk("reload_raddr_before", mem_raddr, 3);
        postEdge();
        chk("reload_cpu_hold", cpu_hold, 1);
        chk("reload_done", done, 0);
        drive(0, 0, 8'h00, 1, 4'd3);
        preEdge();
        chk("reload_mem_re_after", mem_re, 0);
        postEdge();

        // Restart mid-download: concurrent 0xAA is dropped, next write lands at 0.
        drive(1, 0, 8'h00, 0, 4'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 8'h30 + 8'(i), 0, 4'd0);
            tick();
        end
        drive(1, 1, 8'hAA, 0, 4'd0);
        preEdge();
        chk("restart_ready_low", ld_ready, 0);
        postEdge();
        chk("restart_no_write", mem_we, 0);
        drive(0, 1, 8'h11, 0, 4'd0);
        tick();
        chk("restart_we", mem_we, 1);
        chk("restart_waddr", mem_waddr, 0);
        chk("restart_wdata", mem_wdata, 8'h11);

        // Async reset between edges after 10 bytes.
        drive(1, 0, 8'h00, 0, 4'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 8'h50 + 8'(i), 0, 4'd0);
            tick();
        end
        chk("pre_reset_we", mem_we, 1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkResetOutputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        weSeen = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'h55, 0, 4'd0);
            tick();
        end
        chk("post_reset_no_writes", weSeen, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (rst) modelReset();
            d = 8'($urandom_range(0, 255));
            if (active && got.size() == 16 && $urandom_range(0, 1) == 1) begin
                d = 8'((256 - (gotSum() % 256)) % 256);
            end
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, d,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            tick();
        end
        rst = 1'b0;
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
